seg7_scan: RTL
==============

SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, range 1..8.
REQ-002 Parameter CLK_DIV, default 50000: clock cycles per digit slot, minimum 4.
REQ-003 Parameter BLANK_CYC, default 16: cycles at start of each slot with all anodes off; SHALL be < CLK_DIV.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 load  in  1  one-cycle strobe; captures hex_in, dp_in into shadow register.
REQ-007 hex_in  in  4*NUM_DIGITS  digit values, nibble k = digit k, digit 0 least significant.
REQ-008 dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
REQ-009 lz_en  in  1  leading-zero suppression enable, sampled live.
REQ-010 blank  in  1  1 = all anodes off, sampled live.
REQ-011 bright  in  4  brightness level 0..15.
REQ-012 seg  out  8  active-low segments: bit 7 = dp, bits 6:0 = g,f,e,d,c,b,a.
REQ-013 an  out  NUM_DIGITS  active-low anode enables, bit k = digit k.
REQ-014 frame_done  out  1  one-cycle pulse when digit index wraps to 0.

Function
REQ-015 Slot counter SHALL count 0..CLK_DIV-1 and wrap to 0; digit index SHALL increment on the cycle slot counter = CLK_DIV-1, wrapping NUM_DIGITS-1 -> 0.
REQ-016 Wrap cycle (index NUM_DIGITS-1 -> 0) SHALL be the frame boundary; frame_done SHALL be 1 in the cycle after it, 0 otherwise.
REQ-017 load SHALL write shadow register and set pending flag; active register SHALL take shadow only at a frame boundary, then clear pending (no mid-frame tearing).
REQ-018 load coincident with frame boundary SHALL write hex_in/dp_in directly into active register and leave pending clear.
REQ-019 Repeated load before a boundary: last captured value SHALL win.
REQ-020 Hex decode, standard a..g, active-low for 0-F: 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90,A=88,b=83,C=C6,d=A1,E=86,F=8E (seg, dp bit off).
REQ-021 seg[7] SHALL be 0 when active dp for current digit is 1, else 1.
REQ-022 lz_en=1: digit k (k>=1) SHALL show seg[6:0]=7F when it and all higher digits are 0; digit 0 never suppressed; dp unaffected.
REQ-023 4-bit free-running PWM counter increments every cycle; digit lit only when pwm_cnt <= bright (bright=15 always lit, bright=0 lit 1/16).
REQ-024 an[k]=0 only when k = digit index AND slot counter >= BLANK_CYC AND blank=0 AND PWM lit; all other an bits 1.
REQ-025 seg and an SHALL be registered; they reflect counter state with exactly one cycle latency.
REQ-026 When no anode is asserted, seg SHALL be FF.
REQ-027 Counters sized with clog2 of their range; no overflow beyond stated wrap values.

Reset
REQ-028 rst_n=0 at a clock edge SHALL set slot counter, digit index, PWM counter, pending, shadow, active to 0; seg=FF, an all 1, frame_done=0 on next cycle.
REQ-029 Reset mid-frame or coincident with load SHALL discard the load; first digit slot after release starts at index 0 with slot counter 0.

Verification (NUM_DIGITS=4, CLK_DIV=8, BLANK_CYC=2, bright=15, blank=0)
REQ-030 Reset then load hex_in=16'h1234, dp_in=0 at boundary -> digit0 seg=99, digit1 B0, digit2 A4, digit3 F9; an=1110/1101/1011/0111 in turn, each low 6 cycles per 8-cycle slot; frame_done every 32 cycles.
REQ-031 lz_en=1, load 16'h0070 -> digit3 and digit2 seg=FF, digit1 F8, digit0 C0; load 16'h0000 -> only digit0 shows C0.
REQ-032 load 16'hABCD mid-frame (index 1) -> displayed digits unchanged until next frame_done, then 86? no: digit0 A1, digit1 C6, digit2 83, digit3 88 from next frame; two loads in one frame -> second value only.
REQ-033 dp_in=4'b0100 -> seg[7]=0 only while an[2]=0; bright=3 -> an low only when pwm_cnt<=3 (4 of every 16 cycles within unblanked window); blank=1 -> an all 1, seg=FF.
REQ-034 rst_n=0 asserted for one cycle during digit2 with pending load -> seg=FF, an=1111 next cycle, active data 0 (digit0 shows C0 after release), no frame_done until 32 cycles later.

Source files
------------

// File: rtl/seg7_scan_if.sv
// seg7_scan_if: display data, control and drive signals of the 7-segment scanner
interface seg7_scan_if #(
    parameter int NUM_DIGITS = 4
) ();
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   hex_in;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic                      lz_en;
    logic                      blank;
    logic [3:0]                bright;
    logic [7:0]                seg;
    logic [NUM_DIGITS-1:0]     an;
    logic                      frame_done;

    modport master (
        output load, hex_in, dp_in, lz_en, blank, bright,
        input  seg, an, frame_done
    );

    modport slave (
        input  load, hex_in, dp_in, lz_en, blank, bright,
        output seg, an, frame_done
    );
endinterface

// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed 7-segment scanner with frame-synchronous data update, blanking, PWM dimming and leading-zero suppression
module seg7_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000,
    parameter int BLANK_CYC  = 16
) (
    input logic        clk,
    input logic        rst_n,
    seg7_scan_if.slave bus
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int HW = 4 * NUM_DIGITS;
    localparam logic [CW-1:0] SLOT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] SLOT_BLANK = CW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]         slot_cnt;
    logic [IW-1:0]         dig_idx;
    logic [3:0]            pwm_cnt;
    logic                  pending;
    logic [HW-1:0]         shadow_hex;
    logic [HW-1:0]         active_hex;
    logic [NUM_DIGITS-1:0] shadow_dp;
    logic [NUM_DIGITS-1:0] active_dp;
    logic                  slot_end;
    logic                  frame_end;
    logic [3:0]            cur_hex;
    logic                  cur_dp;
    logic                  cur_sup;
    logic                  zero_run;
    logic                  lit;
    logic [7:0]            seg_next;
    logic [NUM_DIGITS-1:0] an_next;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    assign slot_end  = slot_cnt == SLOT_LAST;
    assign frame_end = slot_end && dig_idx == IDX_LAST;

    // slot, digit and PWM counters; the last slot of the last digit closes the frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            dig_idx  <= '0;
            pwm_cnt  <= '0;
        end else begin
            slot_cnt <= slot_end ? '0 : slot_cnt + CW'(1);
            dig_idx  <= frame_end ? '0 : slot_end ? dig_idx + IW'(1) : dig_idx;
            pwm_cnt  <= pwm_cnt + 4'd1;
        end
    end

    // loads park in the shadow register and reach the display only at a frame boundary
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending    <= 1'b0;
            shadow_hex <= '0;
            shadow_dp  <= '0;
            active_hex <= '0;
            active_dp  <= '0;
        end else if (frame_end) begin
            pending <= 1'b0;
            if (bus.load) begin
                active_hex <= bus.hex_in;
                active_dp  <= bus.dp_in;
            end else if (pending) begin
                active_hex <= shadow_hex;
                active_dp  <= shadow_dp;
            end
        end else if (bus.load) begin
            pending    <= 1'b1;
            shadow_hex <= bus.hex_in;
            shadow_dp  <= bus.dp_in;
        end
    end

    // select the current digit, apply suppression of leading zeros, and gate the anode
    always_comb begin
        cur_hex  = '0;
        cur_dp   = 1'b0;
        cur_sup  = 1'b0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && active_hex[4*k +: 4] == 4'h0;
            if (dig_idx == IW'(k)) begin
                cur_hex = active_hex[4*k +: 4];
                cur_dp  = active_dp[k];
                cur_sup = bus.lz_en && zero_run && k != 0;
            end
        end
        lit = slot_cnt >= SLOT_BLANK && !bus.blank && pwm_cnt <= bus.bright;
        an_next = '1;
        for (int k = 0; k < NUM_DIGITS; k++)
            an_next[k] = !(lit && dig_idx == IW'(k));
        seg_next = lit ? {~cur_dp, cur_sup ? 7'h7F : hex7(cur_hex)} : 8'hFF;
    end

    // registered drive outputs, one cycle behind the counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.seg        <= 8'hFF;
            bus.an         <= '1;
            bus.frame_done <= 1'b0;
        end else begin
            bus.seg        <= seg_next;
            bus.an         <= an_next;
            bus.frame_done <= frame_end;
        end
    end
endmodule
